// File: rtl/flash_read_seq.sv
// Parallel-flash burst read sequencer: SETUP / WAIT / RECOVER per byte, paced by a shared access-delay timer.
// Optional WAIT watchdog enabled by defining FLASH_RD_TIMEOUT_EN (sets sticky err and aborts the burst).
module flash_read_seq #(
   parameter int ADDR_W  = 24,
   parameter int TIMEOUT = 255
) (
   input  logic              CLK_50MHZ,
   input  logic              RST,
   input  logic              req,
   input  logic [ADDR_W-1:0] addr,
   input  logic [3:0]        len,
   output logic              busy,
   output logic              valid,
   output logic [7:0]        rd_data,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] SF_A,
   input  logic [7:0]        SF_D,
   output logic              SF_CE0,
   output logic              SF_OE,
   output logic              SF_WE,
   output logic              tmr_start,
   input  logic              tmr_done
);

   typedef enum logic [1:0] {IDLE, SETUP, WAIT, RECOVER} state_t;

   state_t     state;
   logic [3:0] remaining;
   logic       abort;

   // Read-only sequencer: the write strobe is never asserted.
   assign SF_WE = 1'b1;

`ifdef FLASH_RD_TIMEOUT_EN
   localparam int TCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   logic [TCNT_W-1:0] tcnt;
`else
   assign abort = 1'b0;
   assign err   = 1'b0;
`endif

   // SF_A doubles as the burst address register, so it is stable through SETUP and WAIT by construction.
   always_ff @(posedge CLK_50MHZ or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         remaining <= 4'd0;
         busy      <= 1'b0;
         valid     <= 1'b0;
         done      <= 1'b0;
         rd_data   <= 8'd0;
         SF_A      <= '0;
         SF_CE0    <= 1'b1;
         SF_OE     <= 1'b1;
         tmr_start <= 1'b0;
`ifdef FLASH_RD_TIMEOUT_EN
         tcnt      <= '0;
         abort     <= 1'b0;
         err       <= 1'b0;
`endif
      end else begin
         valid <= 1'b0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               // A request overlapping the done pulse must still be present next cycle.
               if (req && !done) begin
                  SF_A      <= addr;
                  remaining <= len;
                  busy      <= 1'b1;
                  SF_CE0    <= 1'b0;
                  SF_OE     <= 1'b0;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               tmr_start <= 1'b1;
`ifdef FLASH_RD_TIMEOUT_EN
               tcnt      <= '0;
`endif
               state     <= WAIT;
            end
            WAIT: begin
               if (tmr_done) begin
                  rd_data   <= SF_D;
                  valid     <= 1'b1;
                  tmr_start <= 1'b0;
                  SF_CE0    <= 1'b1;
                  SF_OE     <= 1'b1;
                  state     <= RECOVER;
               end
`ifdef FLASH_RD_TIMEOUT_EN
               else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                  err       <= 1'b1;
                  abort     <= 1'b1;
                  tmr_start <= 1'b0;
                  SF_CE0    <= 1'b1;
                  SF_OE     <= 1'b1;
                  state     <= RECOVER;
               end else begin
                  tcnt <= tcnt + TCNT_W'(1);
               end
`endif
            end
            RECOVER: begin
               if (remaining != 4'd0 && !abort) begin
                  remaining <= remaining - 4'd1;
                  SF_A      <= SF_A + ADDR_W'(1);
                  SF_CE0    <= 1'b0;
                  SF_OE     <= 1'b0;
                  state     <= SETUP;
               end else begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
`ifdef FLASH_RD_TIMEOUT_EN
                  abort <= 1'b0;
`endif
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_read_seq.sv
// Scoreboard bench for flash_read_seq: directed bursts push expected bytes, a negedge monitor pops and compares.
module tb_flash_read_seq;

   logic        clk = 1'b0;
   logic        RST;
   logic        req;
   logic [23:0] addr;
   logic [3:0]  len;
   logic        busy, valid, done, err;
   logic [7:0]  rd_data;
   logic [23:0] SF_A;
   logic [7:0]  SF_D;
   logic        SF_CE0, SF_OE, SF_WE, tmr_start, tmr_done;

   typedef struct {
      logic [23:0] a;
      logic [7:0]  d;
   } exp_t;

   exp_t exp_q[$];
   int   exp_done = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   int   n_valid = 0;
   int   cyc = 0;
   int   setup_cyc = 0;
   logic [23:0] setup_a = '0;
   logic a_moved = 1'b0;

   // Timer model: expires after tmr_lat cycles of tmr_start high.
   int   tmr_lat = 0;
   int   tcnt = 0;
   logic hold0 = 1'b0;
   logic dmode = 1'b0;
   logic [7:0] dconst = 8'h00;

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) tcnt <= tmr_start ? tcnt + 1 : 0;
   assign tmr_done = tmr_start && !hold0 && (tcnt == tmr_lat);
   assign SF_D = dmode ? SF_A[7:0] : dconst;

   flash_read_seq #(.ADDR_W(24), .TIMEOUT(20)) dut (
      .CLK_50MHZ(clk), .RST(RST), .req(req), .addr(addr), .len(len),
      .busy(busy), .valid(valid), .rd_data(rd_data), .done(done), .err(err),
      .SF_A(SF_A), .SF_D(SF_D), .SF_CE0(SF_CE0), .SF_OE(SF_OE), .SF_WE(SF_WE),
      .tmr_start(tmr_start), .tmr_done(tmr_done)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: per-cycle observation, decoupled from stimulus.
   always @(negedge clk) begin
      if (!RST) begin
         if (!SF_CE0 && !tmr_start) begin
            setup_cyc = cyc;
            setup_a   = SF_A;
         end
         if (!SF_CE0 && tmr_start && SF_A !== setup_a) a_moved = 1'b1;
         if (valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", {8'h0, SF_A}, 32'hFFFFFFFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("rd_data", {24'h0, rd_data}, {24'h0, e.d});
               chk("sf_a", {8'h0, SF_A}, {8'h0, e.a});
               chk("latency", cyc - setup_cyc, 2 + tmr_lat);
               chk("sf_a_stable", {31'h0, a_moved}, 32'h0);
            end
            a_moved = 1'b0;
         end
         if (done) begin
            chk("done_expected", (exp_done > 0) ? 1 : 0, 1);
            if (exp_done > 0) exp_done--;
            chk("queue_drained_at_done", exp_q.size(), 0);
            chk("sf_we", {31'h0, SF_WE}, 1);
         end
      end
   end

   task automatic push_burst(input logic [23:0] a, input int l, input logic dm, input logic [7:0] dc);
      exp_t e;
      for (int i = 0; i <= l; i++) begin
         e.a = a + 24'(i);
         e.d = dm ? e.a[7:0] : dc;
         exp_q.push_back(e);
      end
      exp_done++;
   endtask

   task automatic issue(input logic [23:0] a, input logic [3:0] l);
      @(posedge clk); #1;
      req = 1'b1; addr = a; len = l;
      @(posedge clk); #1;
      req = 1'b0;
      chk("busy_after_req", {31'h0, busy}, 1);
   endtask

   task automatic wait_done(input string nm);
      int k;
      for (k = 0; k < 400; k++) begin
         @(negedge clk);
         if (done) break;
      end
      if (k == 400) chk({nm, "_timeout"}, 0, 1);
      @(posedge clk); #1;
      chk({nm, "_busy_low"}, {31'h0, busy}, 0);
   endtask

   initial begin
      int k;
      int wcnt;
      RST = 1'b1; req = 1'b0; addr = '0; len = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'h0, busy}, 0);
      chk("rst_valid", {31'h0, valid}, 0);
      chk("rst_done", {31'h0, done}, 0);
      chk("rst_err", {31'h0, err}, 0);
      chk("rst_rd_data", {24'h0, rd_data}, 0);
      chk("rst_sf_a", {8'h0, SF_A}, 0);
      chk("rst_strobes", {29'h0, SF_CE0, SF_OE, SF_WE}, 7);
      chk("rst_tmr_start", {31'h0, tmr_start}, 0);
      RST = 1'b0;

      // Single read.
      tmr_lat = 3; dmode = 1'b0; dconst = 8'hA5;
      push_burst(24'h000010, 0, 1'b0, 8'hA5);
      issue(24'h000010, 4'd0);
      wait_done("single");

      // Four-byte burst, data = low address byte.
      tmr_lat = 1; dmode = 1'b1;
      push_burst(24'h000100, 3, 1'b1, 8'h00);
      issue(24'h000100, 4'd3);
      wait_done("burst");

      // Address wrap at top of space.
      tmr_lat = 0;
      push_burst(24'hFFFFFE, 3, 1'b1, 8'h00);
      issue(24'hFFFFFE, 4'd3);
      wait_done("wrap");

      // req held through busy with addr changing: one burst only.
      tmr_lat = 2;
      push_burst(24'h000200, 1, 1'b1, 8'h00);
      @(posedge clk); #1;
      req = 1'b1; addr = 24'h000200; len = 4'd1;
      @(posedge clk);
      for (k = 0; k < 400; k++) begin
         @(negedge clk);
         if (done) break;
         addr = addr + 24'h000011;
      end
      req = 1'b0;
      if (k == 400) chk("held_req_timeout", 0, 1);
      repeat (4) @(posedge clk);
      #1;
      chk("held_req_busy_low", {31'h0, busy}, 0);

      // Reset pulse during WAIT of byte 2.
      tmr_lat = 6; n_valid = 0;
      push_burst(24'h000500, 5, 1'b1, 8'h00);
      issue(24'h000500, 4'd5);
      for (k = 0; k < 400; k++) begin
         @(negedge clk);
         if (n_valid >= 1 && tmr_start) break;
      end
      if (k == 400) chk("rst_mid_reach_wait", 0, 1);
      #2;
      RST = 1'b1;
      exp_q.delete();
      exp_done = 0;
      #1;
      chk("rst_mid_strobes", {30'h0, SF_CE0, SF_OE}, 3);
      chk("rst_mid_tmr_start", {31'h0, tmr_start}, 0);
      chk("rst_mid_busy", {31'h0, busy}, 0);
      @(posedge clk); @(posedge clk); #1;
      RST = 1'b0;
      n_valid = 0;
      repeat (20) @(posedge clk);
      #1;
      chk("rst_mid_no_valid", n_valid, 0);

      // Fresh request after the abort.
      tmr_lat = 2; dmode = 1'b0; dconst = 8'h3C;
      push_burst(24'h000040, 1, 1'b0, 8'h3C);
      issue(24'h000040, 4'd1);
      wait_done("after_rst");

`ifdef FLASH_RD_TIMEOUT_EN
      hold0 = 1'b1; n_valid = 0; wcnt = 0;
      exp_done++;
      issue(24'h000300, 4'd2);
      for (k = 0; k < 400; k++) begin
         @(negedge clk);
         if (tmr_start) wcnt++;
         if (done) break;
      end
      if (k == 400) chk("timeout_done", 0, 1);
      chk("timeout_wait_cycles", wcnt, 20);
      chk("timeout_err", {31'h0, err}, 1);
      chk("timeout_no_valid", n_valid, 0);
      hold0 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("err_sticky", {31'h0, err}, 1);
`else
      wcnt = 0;
      chk("err_tied_low", {31'h0, err} + wcnt, 0);
`endif

      chk("exp_queue_empty", exp_q.size(), 0);
      chk("exp_done_empty", exp_done, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/flash_read_seq.md
FLASH_READ_SEQ -- requirements
Module: flash_read_seq

Interface
REQ-001 Parameter ADDR_W, default 24, flash byte-address width.
REQ-002 Parameter TIMEOUT, default 255, max cycles waiting for tmr_done (used only with FLASH_RD_TIMEOUT_EN).
REQ-003 CLK_50MHZ  input  1  system clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 req  input  1  read request, sampled only in IDLE.
REQ-006 addr  input  ADDR_W  start byte address, captured with req.
REQ-007 len  input  4  burst length minus one (0 = 1 byte, 15 = 16 bytes), captured with req.
REQ-008 busy  output  1  high from cycle after accepted req until return to IDLE.
REQ-009 valid  output  1  one-cycle pulse: rd_data holds a new byte.
REQ-010 rd_data  output  8  last captured flash byte.
REQ-011 done  output  1  one-cycle pulse after last byte of burst.
REQ-012 err  output  1  sticky timeout flag (constant 0 without FLASH_RD_TIMEOUT_EN).
REQ-013 SF_A  output  ADDR_W  flash address.
REQ-014 SF_D  input  8  flash data.
REQ-015 SF_CE0, SF_OE, SF_WE  output  1 each  flash strobes, active-low; SF_WE constant 1.
REQ-016 tmr_start  output  1  access-delay timer start level.
REQ-017 tmr_done  input  1  timer expiry from the shared access-delay timer.

Function
REQ-018 States SHALL be IDLE, SETUP, WAIT, RECOVER; encoding free.
REQ-019 IDLE: req=1 captures addr into address register, len into remaining counter, next state SETUP, busy=1 next cycle.
REQ-020 SETUP (1 cycle): SF_A=address register, SF_CE0=0, SF_OE=0, tmr_start=0; next WAIT.
REQ-021 WAIT: SF_CE0=0, SF_OE=0, tmr_start=1 held level until tmr_done sampled 1; no dependence on tmr_done while not in WAIT.
REQ-022 Cycle tmr_done=1 in WAIT: rd_data<=SF_D; next cycle valid=1 for exactly one cycle, state RECOVER, tmr_start=0.
REQ-023 RECOVER (1 cycle): SF_CE0=1, SF_OE=1; if remaining>0: remaining-1, address+1, next SETUP; else next IDLE, done=1 and busy=0 in the following cycle.
REQ-024 Address increment SHALL wrap modulo 2^ADDR_W (all-ones -> 0) without error.
REQ-025 req while busy=1 SHALL be ignored, not queued.
REQ-026 req and done in same cycle: done completes; req accepted only if still high next cycle in IDLE.
REQ-027 Per-byte latency from SETUP entry to valid = 2 + N cycles, N = cycles tmr_start high before tmr_done.
REQ-028 SF_A SHALL remain stable through SETUP and WAIT.

Reset
REQ-029 RST=1 SHALL immediately force IDLE, busy=0, valid=0, done=0, err=0, rd_data=0, SF_A=0, SF_CE0=1, SF_OE=1, SF_WE=1, tmr_start=0.
REQ-030 RST mid-burst SHALL abort without done or valid; first request after release starts fresh.

Configuration
REQ-031 Macro FLASH_RD_TIMEOUT_EN defined: counter clears in SETUP, counts in WAIT; reaching TIMEOUT with tmr_done=0 sets err=1, aborts burst via RECOVER -> IDLE with done pulse, no valid; err clears only on RST.
REQ-032 Macro undefined: no counter, WAIT waits indefinitely, err tied 0.

Verification
REQ-033 Single read: addr=0x000010, len=0, timer done after 3 cycles, SF_D=0xA5 -> one valid with rd_data=0xA5, one done, busy back to 0.
REQ-034 Burst: addr=0x000100, len=3, SF_D=low byte of SF_A -> valids 0x00,0x01,0x02,0x03, SF_A 0x100..0x103, single done.
REQ-035 Wrap: addr=0xFFFFFE, len=3 -> SF_A sequence 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001, four valids.
REQ-036 req=1 throughout busy with addr changing -> exactly one burst, addresses from first capture only.
REQ-037 RST pulse during WAIT of byte 2 of len=5 burst -> strobes high, tmr_start=0, no further valid/done; new req runs normally.
REQ-038 FLASH_RD_TIMEOUT_EN, TIMEOUT=20, tmr_done held 0 -> err=1 after 20 WAIT cycles, done pulse, no valid.
